// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped down-counter timer: register map,
// CTRL bit positions, mode codes and FSM state encoding.
package timer_pkg;

  localparam logic [1:0] CTRL_ADDR   = 2'd0;
  localparam logic [1:0] PRESET_ADDR = 2'd1;
  localparam logic [1:0] COUNT_ADDR  = 2'd2;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_MODE_MSB = 2;
  localparam int unsigned CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_counter_if.sv
// CPU peripheral-bus view of the timer: register access plus the irq/ack pair.
interface timer_counter_if;

  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        int_ack;
  logic        irq;

  modport master (
    output addr,
    output we,
    output din,
    output int_ack,
    input  dout,
    input  irq
  );

  modport slave (
    input  addr,
    input  we,
    input  din,
    input  int_ack,
    output dout,
    output irq
  );

endinterface

// File: rtl/timer_counter.sv
// 32-bit down-counter timer with one-shot / auto-reload modes and a pending
// interrupt flag; register file, FSM and pending logic in one module.
module timer_counter
  import timer_pkg::*;
#(
  parameter bit RELOAD_PULSE = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  timer_counter_if.slave bus
);

  logic        r_en;
  logic [1:0]  r_mode;
  logic        r_im;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_pending;
  state_e      r_state;

  state_e      w_state_nxt;
  logic        w_ctrl_wr;
  logic        w_preset_wr;
  logic        w_en_eff;
  logic        w_reload;
  logic        w_load_cnt;
  logic        w_dec_cnt;
  logic        w_clr_cnt;
  logic        w_set_pend;
  logic        w_hw_clr_en;
  logic        w_auto_clr;
  logic        w_pend_nxt;
  logic        w_unused_din;

  assign w_ctrl_wr    = bus.we && (bus.addr == CTRL_ADDR);
  assign w_preset_wr  = bus.we && (bus.addr == PRESET_ADDR);
  // A CTRL write in the same cycle overrides the stored EN for stop decisions.
  assign w_en_eff     = w_ctrl_wr ? bus.din[CTRL_EN_BIT] : r_en;
  assign w_reload     = (r_mode == MODE_RELOAD);
  assign w_unused_din = ^bus.din[31:4];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (r_en) w_state_nxt = LOAD;
      LOAD: w_state_nxt = CNT;
      CNT: begin
        if (!w_en_eff) begin
          w_state_nxt = IDLE;
        end else if (r_count <= 32'd1) begin
          w_state_nxt = INT;
        end
      end
      INT: begin
        if (!w_en_eff || !w_reload) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = LOAD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State-decoded datapath controls
  always_comb begin
    w_load_cnt  = 1'b0;
    w_dec_cnt   = 1'b0;
    w_clr_cnt   = 1'b0;
    w_set_pend  = 1'b0;
    w_hw_clr_en = 1'b0;
    unique case (r_state)
      IDLE: ;
      LOAD: w_load_cnt = 1'b1;
      CNT: begin
        if (w_en_eff) begin
          if (r_count > 32'd1) begin
            w_dec_cnt = 1'b1;
          end else begin
            w_clr_cnt = 1'b1;
          end
        end
      end
      INT: begin
        w_set_pend  = 1'b1;
        w_hw_clr_en = !w_reload;
      end
      default: ;
    endcase
  end

  assign w_auto_clr = RELOAD_PULSE && w_reload && r_pending;
  // Set has priority over every clear source.
  assign w_pend_nxt = w_set_pend ? 1'b1 :
                      (bus.int_ack || w_ctrl_wr || w_auto_clr) ? 1'b0 : r_pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en      <= 1'b0;
      r_mode    <= MODE_ONESHOT;
      r_im      <= 1'b0;
      r_preset  <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_en   <= bus.din[CTRL_EN_BIT];
        r_mode <= bus.din[CTRL_MODE_MSB:CTRL_MODE_LSB];
        r_im   <= bus.din[CTRL_IM_BIT];
      end else if (w_hw_clr_en) begin
        r_en <= 1'b0;
      end

      if (w_preset_wr) begin
        r_preset <= bus.din;
      end

      if (w_load_cnt) begin
        r_count <= r_preset;
      end else if (w_dec_cnt) begin
        r_count <= r_count - 32'd1;
      end else if (w_clr_cnt) begin
        r_count <= '0;
      end

      r_pending <= w_pend_nxt;
    end
  end

  assign bus.irq = r_pending & r_im;

  always_comb begin
    bus.dout = '0;
    case (bus.addr)
      CTRL_ADDR:   bus.dout = {28'd0, r_im, r_mode, r_en};
      PRESET_ADDR: bus.dout = r_preset;
      COUNT_ADDR:  bus.dout = r_count;
      default:     bus.dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter with hand-computed expectations.
module tb_timer_counter;
  import timer_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [31:0] rd_val;

  int unsigned exp_cnt_reload [16] = '{0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0};

  timer_counter_if bus ();

  timer_counter #(.RELOAD_PULSE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.din  = d;
    bus.we   = 1'b1;
    @(posedge clk);
    #1;
    bus.we   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.dout;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {31'd0, bus.irq}, {31'd0, exp});
  endtask

  task automatic ack_pulse();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b0;
    bus.addr    = 2'd0;
    bus.we      = 1'b0;
    bus.din     = '0;
    bus.int_ack = 1'b0;

    // Reset state
    #7;
    chk_reg("rst_ctrl", CTRL_ADDR, 32'd0);
    chk_reg("rst_preset", PRESET_ADDR, 32'd0);
    chk_reg("rst_count", COUNT_ADDR, 32'd0);
    chk_reg("rst_addr3", 2'd3, 32'd0);
    chk_irq("rst_irq", 1'b0);
    #1 reset = 1'b1;

    // Asynchronous reset mid-count
    bus_write(PRESET_ADDR, 32'd10);
    bus_write(CTRL_ADDR, 32'd1);
    repeat (5) tick();
    chk_reg("mid_count7", COUNT_ADDR, 32'd7);
    #2 reset = 1'b0;
    #1;
    chk_reg("async_count", COUNT_ADDR, 32'd0);
    chk_reg("async_ctrl", CTRL_ADDR, 32'd0);
    chk_reg("async_preset", PRESET_ADDR, 32'd0);
    chk_irq("async_irq", 1'b0);
    #1 reset = 1'b1;
    repeat (3) tick();
    chk_reg("post_rst_count", COUNT_ADDR, 32'd0);
    chk_irq("post_rst_irq", 1'b0);

    // One-shot, PRESET=5: irq after 8th edge, held until ack
    bus_write(PRESET_ADDR, 32'd5);
    bus_write(CTRL_ADDR, 32'h9);
    repeat (7) tick();
    chk_irq("os_irq_e7", 1'b0);
    tick();
    chk_irq("os_irq_e8", 1'b1);
    chk_reg("os_ctrl_en_clr", CTRL_ADDR, 32'h8);
    chk_reg("os_count0", COUNT_ADDR, 32'd0);
    repeat (3) tick();
    chk_irq("os_irq_held", 1'b1);
    ack_pulse();
    chk_irq("os_irq_acked", 1'b0);
    repeat (10) tick();
    chk_irq("os_no_second", 1'b0);

    // Auto-reload, PRESET=3: one-cycle pulses every 5 cycles
    bus_write(PRESET_ADDR, 32'd3);
    bus_write(CTRL_ADDR, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      tick();
      rd(COUNT_ADDR, rd_val);
      check($sformatf("ar_count_k%0d", k), rd_val, exp_cnt_reload[k-1]);
      chk_irq($sformatf("ar_irq_k%0d", k), (k == 6) || (k == 11) || (k == 16));
    end
    bus_write(CTRL_ADDR, 32'd0);
    repeat (3) tick();

    // Auto-reload with IM=0: irq never asserts
    bus_write(PRESET_ADDR, 32'd3);
    bus_write(CTRL_ADDR, 32'h3);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_irq($sformatf("masked_irq_k%0d", k), 1'b0);
    end
    bus_write(CTRL_ADDR, 32'd0);
    repeat (3) tick();

    // One-shot IM=0 leaves pending; unmasking via CTRL write also clears it
    bus_write(PRESET_ADDR, 32'd2);
    bus_write(CTRL_ADDR, 32'h1);
    repeat (7) tick();
    chk_irq("mask_pend_irq", 1'b0);
    bus_write(CTRL_ADDR, 32'h8);
    chk_irq("unmask_clr_irq", 1'b0);
    repeat (2) tick();
    chk_irq("unmask_clr_irq2", 1'b0);

    // int_ack coinciding with set: set wins
    bus_write(PRESET_ADDR, 32'd1);
    bus_write(CTRL_ADDR, 32'h9);
    repeat (3) tick();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    chk_irq("ack_vs_set", 1'b1);
    tick();
    chk_irq("ack_vs_set_held", 1'b1);
    ack_pulse();
    chk_irq("ack_vs_set_clr", 1'b0);

    // PRESET write mid-count only takes effect at next LOAD
    bus_write(PRESET_ADDR, 32'd6);
    bus_write(CTRL_ADDR, 32'hB);
    repeat (4) tick();
    chk_reg("pw_count4", COUNT_ADDR, 32'd4);
    bus_write(PRESET_ADDR, 32'd9);
    chk_reg("pw_count3", COUNT_ADDR, 32'd3);
    tick();
    chk_reg("pw_count2", COUNT_ADDR, 32'd2);
    tick();
    chk_reg("pw_count1", COUNT_ADDR, 32'd1);
    tick();
    chk_reg("pw_count0", COUNT_ADDR, 32'd0);
    chk_irq("pw_irq_int", 1'b0);
    tick();
    chk_irq("pw_irq_pulse", 1'b1);
    tick();
    chk_reg("pw_reload9", COUNT_ADDR, 32'd9);
    chk_irq("pw_irq_gone", 1'b0);
    bus_write(CTRL_ADDR, 32'd0);
    chk_reg("pw_stop_hold", COUNT_ADDR, 32'd9);
    repeat (2) tick();

    // PRESET=0 expires after one CNT cycle
    bus_write(PRESET_ADDR, 32'd0);
    bus_write(CTRL_ADDR, 32'h9);
    repeat (3) tick();
    chk_irq("p0_irq_e3", 1'b0);
    tick();
    chk_irq("p0_irq_e4", 1'b1);
    chk_reg("p0_ctrl", CTRL_ADDR, 32'h8);
    ack_pulse();

    // EN=0 freezes COUNT; EN=1 reloads rather than resumes
    bus_write(PRESET_ADDR, 32'd5);
    bus_write(CTRL_ADDR, 32'h1);
    repeat (5) tick();
    chk_reg("fz_count2", COUNT_ADDR, 32'd2);
    bus_write(CTRL_ADDR, 32'h0);
    chk_reg("fz_frozen", COUNT_ADDR, 32'd2);
    repeat (3) tick();
    chk_reg("fz_frozen_later", COUNT_ADDR, 32'd2);
    bus_write(CTRL_ADDR, 32'h1);
    tick();
    chk_reg("fz_load_cycle", COUNT_ADDR, 32'd2);
    tick();
    chk_reg("fz_reloaded", COUNT_ADDR, 32'd5);
    bus_write(CTRL_ADDR, 32'h0);
    repeat (2) tick();

    // Register map corners
    bus_write(CTRL_ADDR, 32'hFFFF_FFF8);
    chk_reg("ctrl_hi_ignored", CTRL_ADDR, 32'h8);
    bus_write(COUNT_ADDR, 32'h1234);
    chk_reg("count_wr_ignored", COUNT_ADDR, 32'd5);
    bus_write(2'd3, 32'hDEAD_BEEF);
    chk_reg("addr3_reads0", 2'd3, 32'd0);
    chk_reg("addr3_no_preset", PRESET_ADDR, 32'd5);

    // MODE=2 behaves as one-shot
    bus_write(PRESET_ADDR, 32'd0);
    bus_write(CTRL_ADDR, 32'hD);
    repeat (4) tick();
    chk_irq("m2_irq", 1'b1);
    chk_reg("m2_ctrl", CTRL_ADDR, 32'hC);
    repeat (5) tick();
    chk_irq("m2_irq_held", 1'b1);
    chk_reg("m2_count", COUNT_ADDR, 32'd0);
    ack_pulse();
    chk_irq("m2_acked", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
Memory-mapped 32-bit down-counter timer on the CPU's peripheral bus. It is the interrupt source that drives one HwInt line into the coprocessor's interrupt logic. The CPU programs it with sw/lw. On expiry it raises irq. The CPU's interrupt-acknowledge pulse clears the pending request. Modes are one-shot and auto-reload.

Parameters:
RELOAD_PULSE, 1, in mode 1, irq pending lasts exactly one cycle (1) or holds until acknowledged (0)

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset; registers clear immediately while low
addr  in  2  word address (bus addr[3:2]); 0=CTRL, 1=PRESET, 2=COUNT, 3=unmapped
we  in  1  write strobe, sampled at rising clk edge
din  in  32  write data
dout  out  32  combinational read data for addr
int_ack  in  1  one-cycle acknowledge from CPU interrupt logic; clears pending
irq  out  1  interrupt request to HwInt input

Behaviour:
- Reset (reset low, async): CTRL=0, PRESET=0, COUNT=0, pending=0, state=IDLE, irq=0. dout=0 for every addr.
- CTRL layout:
  - [0] EN
  - [2:1] MODE: 0 one-shot, 1 auto-reload, 2/3 behave as 0
  - [3] IM, the interrupt mask
  - [31:4] read 0 and ignore writes
- Writes:
  - addr0 writes CTRL[3:0] and clears pending.
  - addr1 writes PRESET.
  - addr2 and addr3 are ignored.
  - Reading addr3 returns 0.
- A bus write beats a hardware update of the same register in the same cycle.
- irq = pending & IM, a registered-output path with no combinational path from din.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT:
    - If !EN, go to IDLE and COUNT holds.
    - Else if COUNT>1, decrement.
    - Else (COUNT 1 or 0), COUNT<=0 and go to INT.
    - PRESET=0 therefore expires after one CNT cycle.
  - INT:
    - Set pending.
    - MODE0: hardware clears EN; go to IDLE.
    - MODE1: go to LOAD.
    - In INT, EN=0 written in the same cycle forces IDLE regardless of mode.
- Pending clear:
  - int_ack clears pending.
  - A CTRL write clears pending.
  - If MODE1 and RELOAD_PULSE=1, pending also clears automatically one cycle after being set.
  - If set and clear coincide, set wins.
- Latency: the EN write is sampled at edge E0. LOAD happens at E1, COUNT=N after E2, COUNT=0 and INT after E2+N, and irq is high after E3+N.
- Mid-count updates:
  - A PRESET write mid-count takes effect only at the next LOAD.
  - An EN=0 write mid-count freezes COUNT.
  - A later EN=1 write passes through LOAD, so COUNT reloads from PRESET and does not resume.
- Mode change mid-count takes effect at the next INT.
- COUNT is 32-bit unsigned; no wrap below 0.

Decomposition:
- Shared package timer_pkg holds:
  - register address constants CTRL_ADDR/PRESET_ADDR/COUNT_ADDR
  - CTRL bit positions EN/MODE/IM
  - mode constants MODE_ONESHOT/MODE_RELOAD
  - the 2-bit state encoding IDLE/LOAD/CNT/INT
- No sub-module: register file, FSM and pending flag stay in one module.

Test Plan:
- Hold reset low mid-count (COUNT=7, EN=1), no clk edge -> COUNT=0, CTRL=0, irq=0 immediately; after release state IDLE, no irq.
- PRESET=5, CTRL=0b1001 (EN, one-shot, IM) -> irq rises after 8th edge past write edge; CTRL reads 0b1000; irq stays high until int_ack pulse, low the next cycle; no second irq.
- PRESET=3, CTRL=0b1011 (auto-reload), RELOAD_PULSE=1 -> irq one-cycle pulses every 5 cycles. COUNT sequence is 3,2,1,0, then reload. No int_ack needed.
- Same setup with IM=0 -> pending set internally, irq stays 0. Writing IM=1 via CTRL clears pending, so irq stays 0.
- int_ack asserted in the same cycle pending is set -> pending stays 1 and irq high next cycle. A CPU PRESET write of 9 mid-count with COUNT=4 -> COUNT continues 3,2,1,0; next reload loads 9.
- preset=0, EN=1 -> irq after 4 edges. Write EN=0 at COUNT=2 -> COUNT frozen at 2. Write EN=1 -> reload from PRESET.
